projectile_pool: RTL and testbench

N-channel projectile manager for the doodle's cannon fire. It generalises the fixed three-cannon logic into a parametrised pool with lowest-free-slot allocation, per-slot speed, fire cooldown, pause freeze, scroll compensation and a shot counter. It sits beside the jump/physics block: it takes the doodle position as the launch origin and feeds projectile positions to the sprite renderer. All motion advances once per frame_tick, which is a one-Clk-cycle pulse derived from the frame clock.

---
 rtl/projectile_pool_if.sv | 29 ++
 rtl/projectile_pool.sv | 127 ++++++++++++
 tb/tb_projectile_pool.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/projectile_pool_if.sv
// Bundle of frame-rate control inputs and projectile state outputs for the projectile pool.
// The master side drives ticks, fire requests and the launch origin; the slave side is the pool.
interface projectile_pool_if #(
  parameter int unsigned N_PROJ = 3,
  parameter int unsigned POS_W  = 10
);
  logic                      frame_tick;
  logic                      fire;
  logic                      pause;
  logic [POS_W-1:0]          originX;
  logic [POS_W-1:0]          originY;
  logic                      scroll_en;
  logic [POS_W-1:0]          scroll_dy;
  logic [N_PROJ*POS_W-1:0]   projX;
  logic [N_PROJ*POS_W-1:0]   projY;
  logic [N_PROJ-1:0]         active;
  logic                      fire_ack;
  logic [15:0]               shots_fired;

  modport master (
    output frame_tick, fire, pause, originX, originY, scroll_en, scroll_dy,
    input  projX, projY, active, fire_ack, shots_fired
  );

  modport slave (
    input  frame_tick, fire, pause, originX, originY, scroll_en, scroll_dy,
    output projX, projY, active, fire_ack, shots_fired
  );
endinterface

// File: rtl/projectile_pool.sv
// N-slot projectile manager: lowest-free-slot launch with cooldown, per-slot upward speed,
// scroll compensation, top-line retirement and pause freeze. State advances only on frame_tick.
module projectile_pool #(
  parameter int unsigned N_PROJ     = 3,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned SPEED_W    = 5,
  parameter int unsigned BASE_SPEED = 6,
  parameter int unsigned SPEED_STEP = 4,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned Y_LIMIT    = 25,
  parameter int unsigned Y_MAX      = 479
) (
  input logic               Clk,
  input logic               Reset,
  projectile_pool_if.slave  bus
);

  localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned IDX_W = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   wide_t;

  function automatic logic [SPEED_W-1:0] speed_of(input int unsigned idx);
    return SPEED_W'(BASE_SPEED + idx * SPEED_STEP);
  endfunction

  pos_t              x_q [N_PROJ];
  pos_t              y_q [N_PROJ];
  pos_t              x_d [N_PROJ];
  pos_t              y_d [N_PROJ];
  logic [N_PROJ-1:0] act_q, act_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [15:0]       shots_q, shots_d;
  logic              ack_q, ack_d;

  logic              step, launch, have_free;
  logic [IDX_W-1:0]  free_idx;
  wide_t             spd, climb, moved;

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    // Only slots idle at the start of the tick are candidates, so a slot retiring this tick
    // can never be relaunched on the same tick.
    for (int i = N_PROJ - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end

    step   = bus.frame_tick && !bus.pause;
    launch = step && bus.fire && (cd_q == '0) && (bus.originY > POS_W'(Y_LIMIT)) && have_free;

    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    cd_d    = cd_q;
    shots_d = shots_q;
    ack_d   = 1'b0;
    spd     = '0;
    climb   = '0;
    moved   = '0;

    if (step) begin
      for (int i = 0; i < N_PROJ; i++) begin
        spd   = wide_t'(speed_of(i));
        climb = {1'b0, y_q[i]} - spd;
        moved = climb + (bus.scroll_en ? {1'b0, bus.scroll_dy} : wide_t'(0));
        // Retirement test ignores scroll and is done as y <= limit + speed to avoid underflow.
        if (!act_q[i] || ({1'b0, y_q[i]} <= wide_t'(Y_LIMIT) + spd)) begin
          act_d[i] = 1'b0;
          x_d[i]   = bus.originX;
          y_d[i]   = bus.originY;
        end else if (moved > wide_t'(Y_MAX)) begin
          y_d[i] = POS_W'(Y_MAX);
        end else begin
          y_d[i] = moved[POS_W-1:0];
        end
      end

      if (launch) begin
        act_d[free_idx] = 1'b1;
        cd_d            = CD_W'(COOLDOWN);
        shots_d         = shots_q + 16'd1;
        ack_d           = 1'b1;
      end else if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      act_q   <= '0;
      cd_q    <= '0;
      shots_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      cd_q    <= cd_d;
      shots_q <= shots_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    bus.projX = '0;
    bus.projY = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      bus.projX[i*POS_W +: POS_W] = x_q[i];
      bus.projY[i*POS_W +: POS_W] = y_q[i];
    end
  end

  assign bus.active      = act_q;
  assign bus.fire_ack    = ack_q;
  assign bus.shots_fired = shots_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: hand-computed slot positions, acks and counters
// across launch, cooldown, retirement, scroll/clamp and pause sequences.
module tb_projectile_pool;
  localparam int unsigned N_PROJ = 3;
  localparam int unsigned POS_W  = 10;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  projectile_pool_if #(.N_PROJ(N_PROJ), .POS_W(POS_W)) bus ();

  projectile_pool #(
    .N_PROJ(N_PROJ), .POS_W(POS_W), .SPEED_W(5), .BASE_SPEED(6), .SPEED_STEP(4),
    .COOLDOWN(8), .Y_LIMIT(25), .Y_MAX(479)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot_x(input int i);
    return 32'(bus.projX[i*POS_W +: POS_W]);
  endfunction

  function automatic logic [31:0] slot_y(input int i);
    return 32'(bus.projY[i*POS_W +: POS_W]);
  endfunction

  // One frame strobe; returns on the following falling edge with the tick's effect visible.
  task automatic tick();
    @(negedge Clk);
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic set_origin(input int x, input int y);
    bus.originX = POS_W'(x);
    bus.originY = POS_W'(y);
  endtask

  task automatic check_slot(input string tag, input int i, input int ex, input int ey);
    check_eq($sformatf("%s X%0d", tag, i), slot_x(i), 32'(ex));
    check_eq($sformatf("%s Y%0d", tag, i), slot_y(i), 32'(ey));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.fire       = 1'b0;
    bus.pause      = 1'b0;
    bus.scroll_en  = 1'b0;
    bus.scroll_dy  = '0;
    set_origin(320, 240);

    // Reset state and idle tracking
    do_reset();
    check_eq("rst active", bus.active, 0);
    check_eq("rst ack", bus.fire_ack, 0);
    check_eq("rst shots", bus.shots_fired, 0);
    check_slot("rst", 0, 0, 0);
    check_slot("rst", 2, 0, 0);
    repeat (3) tick();
    check_eq("idle active", bus.active, 0);
    check_eq("idle shots", bus.shots_fired, 0);
    for (int i = 0; i < N_PROJ; i++) check_slot("idle", i, 320, 240);

    // originY at the limit is rejected; idle slots follow it
    set_origin(320, 25);
    bus.fire = 1'b1;
    tick();
    check_eq("lowY ack", bus.fire_ack, 0);
    check_eq("lowY active", bus.active, 0);
    check_slot("lowY", 0, 320, 25);

    set_origin(320, 240);
    tick();
    check_eq("fire ack", bus.fire_ack, 1);
    check_eq("fire active", bus.active, 3'b001);
    check_eq("fire shots", bus.shots_fired, 1);
    check_slot("fire", 0, 320, 240);
    @(negedge Clk);
    check_eq("ack one cycle", bus.fire_ack, 0);
    bus.fire = 1'b0;
    tick();
    check_slot("move1", 0, 320, 234);
    check_slot("move1", 1, 320, 240);
    check_slot("move1", 2, 320, 240);

    // Fire held for 20 ticks: launches at 0, 9, 18
    do_reset();
    set_origin(320, 240);
    bus.fire = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      check_eq($sformatf("hold ack t%0d", t), bus.fire_ack, 32'((t == 0) || (t == 9) || (t == 18)));
    end
    bus.fire = 1'b0;
    check_eq("hold active", bus.active, 3'b111);
    check_eq("hold shots", bus.shots_fired, 3);
    check_slot("hold", 0, 320, 126);
    check_slot("hold", 1, 320, 140);
    check_slot("hold", 2, 320, 226);

    // Retirement with a simultaneous fire: retiring slot is not relaunched that tick
    do_reset();
    set_origin(320, 400);
    bus.fire = 1'b1;
    tick();                          // t0: slot0
    bus.fire = 1'b0;
    repeat (8) tick();               // t1..t8
    bus.fire = 1'b1;
    tick();                          // t9: slot1
    check_eq("ret l1 active", bus.active, 3'b011);
    bus.fire = 1'b0;
    repeat (8) tick();               // t10..t17
    set_origin(320, 152);
    bus.fire = 1'b1;
    tick();                          // t18: slot2 at 152
    check_eq("ret l2 ack", bus.fire_ack, 1);
    check_slot("ret l2", 2, 320, 152);
    bus.fire = 1'b0;
    repeat (8) tick();               // t19..t26
    check_slot("ret t26", 2, 320, 40);
    tick();                          // t27: 40-14=26 is above the line
    check_slot("ret t27", 2, 320, 26);
    check_eq("ret t27 active", bus.active, 3'b111);
    set_origin(100, 240);
    bus.fire = 1'b1;
    tick();                          // t28: slot2 retires, no idle slot at start
    check_eq("ret ack", bus.fire_ack, 0);
    check_eq("ret active", bus.active, 3'b011);
    check_eq("ret shots", bus.shots_fired, 3);
    check_slot("ret", 2, 100, 240);
    check_slot("ret", 0, 320, 232);
    check_slot("ret", 1, 320, 210);
    tick();                          // t29: relaunch into slot2
    check_eq("relaunch ack", bus.fire_ack, 1);
    check_eq("relaunch active", bus.active, 3'b111);
    check_eq("relaunch shots", bus.shots_fired, 4);
    check_slot("relaunch", 2, 100, 240);
    check_slot("relaunch", 0, 320, 226);
    bus.fire = 1'b0;

    // Scroll compensation and bottom clamp
    do_reset();
    set_origin(320, 100);
    bus.fire = 1'b1;
    tick();
    bus.fire      = 1'b0;
    bus.scroll_en = 1'b1;
    bus.scroll_dy = POS_W'(50);
    tick();
    check_slot("scroll", 0, 320, 144);
    check_slot("scroll", 1, 320, 100);
    bus.scroll_en = 1'b0;
    do_reset();
    set_origin(320, 470);
    bus.fire = 1'b1;
    tick();
    bus.fire      = 1'b0;
    bus.scroll_en = 1'b1;
    tick();
    check_slot("clamp", 0, 320, 479);
    bus.scroll_en = 1'b0;
    tick();
    check_slot("no scroll", 0, 320, 473);
    bus.scroll_dy = '0;

    // Pause freezes positions, cooldown and counter
    do_reset();
    set_origin(320, 240);
    bus.fire = 1'b1;
    tick();                          // launch, cooldown 8
    bus.fire = 1'b0;
    tick();                          // 234, cooldown 7
    bus.pause = 1'b1;
    bus.fire  = 1'b1;
    set_origin(50, 300);
    for (int p = 0; p < 5; p++) begin
      tick();
      check_eq($sformatf("pause ack p%0d", p), bus.fire_ack, 0);
    end
    check_slot("pause", 0, 320, 234);
    check_slot("pause", 1, 320, 240);
    check_eq("pause active", bus.active, 3'b001);
    check_eq("pause shots", bus.shots_fired, 1);
    bus.pause = 1'b0;
    set_origin(320, 240);
    for (int u = 1; u <= 8; u++) begin
      tick();
      check_eq($sformatf("resume ack u%0d", u), bus.fire_ack, 32'(u == 8));
      if (u == 1) check_slot("resume", 0, 320, 228);
    end
    bus.fire = 1'b0;
    check_eq("resume shots", bus.shots_fired, 2);
    check_eq("resume active", bus.active, 3'b011);
    check_slot("resume end", 0, 320, 186);
    check_slot("resume end", 1, 320, 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
